// File: rtl/shot_pkg.sv
// Shared types and constants for the shot sequencer.
package shot_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Right-most playfield column
    localparam int X_MAX = 31;

    // Horizontal direction encoding of the aim vector
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Signed position wide enough to hold one step past either wall (-31..62)
    typedef logic signed [6:0] pos_t;

endpackage

// File: rtl/tick_div.sv
// Frame-tick divider: produces a one-cycle step pulse on every TICK_DIV-th
// enabled tick. The pulse is combinational so the shot moves on the same
// edge that samples the tick. i_clr restarts the count on launch.
module tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_tick,
    output logic o_step
);

    logic [3:0] r_cnt;
    logic       w_last;

    assign w_last = (r_cnt == 4'(TICK_DIV - 1));
    assign o_step = i_en && i_tick && w_last;

    // Count enabled ticks, wrapping to zero on the step tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_en && i_tick) begin
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/shot_ctrl.sv
// Projectile sequencer: latches launcher column and aim on fire, then steps
// the shot across the 32-column playfield every TICK_DIV frame ticks until
// it hits something, passes the top row, or (default build) meets a wall.
// Build option: define SHOT_BOUNCE_EN to make the side walls reflect the
// shot instead of absorbing it.
module shot_ctrl
    import shot_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int Y_MAX    = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fire,
    input  logic       tick,
    input  logic [4:0] x_pos,
    input  logic [4:0] run,
    input  logic [4:0] rise,
    input  logic       dir,
    input  logic       hit,
    output logic       shot_active,
    output logic [4:0] shot_x,
    output logic [4:0] shot_y,
    output logic       shot_done,
    output logic       move_lock
);

    localparam pos_t C_XMAX = pos_t'(X_MAX);
    localparam pos_t C_REFL = pos_t'(2 * X_MAX);

    state_t     r_state, w_state_n;
    logic [4:0] r_x, w_x_n;
    logic [4:0] r_y, w_y_n;
    logic [4:0] r_run, w_run_n;
    logic [4:0] r_rise, w_rise_n;
    logic       r_dir, w_dir_n;
    logic       r_active;
    logic       r_done;
    logic       w_launch;
    logic       w_end;
    logic       w_step;
    logic [5:0] w_y_sum;
    pos_t       w_x_cur;
    pos_t       w_run_s;
    pos_t       w_x_sum;

    tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_launch),
        .i_en    (r_state == FLIGHT),
        .i_tick  (tick),
        .o_step  (w_step)
    );

    // Candidate next position; the 6/7-bit widths expose overflow past the
    // top row and past either wall.
    assign w_y_sum = {1'b0, r_y} + {1'b0, r_rise};
    assign w_x_cur = {2'b00, r_x};
    assign w_run_s = {2'b00, r_run};
    assign w_x_sum = (r_dir == DIR_RIGHT) ? (w_x_cur + w_run_s) : (w_x_cur - w_run_s);

    // Next-state and next-value logic; hit takes priority over a step
    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_run_n   = r_run;
        w_rise_n  = r_rise;
        w_dir_n   = r_dir;
        w_launch  = 1'b0;
        w_end     = 1'b0;
        case (r_state)
            IDLE: begin
                if (fire) begin
                    w_launch  = 1'b1;
                    w_x_n     = x_pos;
                    w_y_n     = 5'd0;
                    w_run_n   = run;
                    // zero rise would never reach the top row
                    w_rise_n  = (rise == 5'd0) ? 5'd1 : rise;
                    w_dir_n   = dir;
                    w_state_n = FLIGHT;
                end
            end
            FLIGHT: begin
                if (hit) begin
                    w_state_n = DONE;
                end else if (w_step) begin
                    if (w_y_sum > 6'(Y_MAX)) begin
                        w_y_n = 5'(Y_MAX);
                        w_end = 1'b1;
                    end else begin
                        w_y_n = w_y_sum[4:0];
                    end
`ifdef SHOT_BOUNCE_EN
                    if (w_x_sum < 7'sd0) begin
                        w_x_n   = 5'(-w_x_sum);
                        w_dir_n = ~r_dir;
                    end else if (w_x_sum > C_XMAX) begin
                        w_x_n   = 5'(C_REFL - w_x_sum);
                        w_dir_n = ~r_dir;
                    end else begin
                        w_x_n = 5'(w_x_sum);
                    end
`else
                    if (w_x_sum < 7'sd0) begin
                        w_x_n = 5'd0;
                        w_end = 1'b1;
                    end else if (w_x_sum > C_XMAX) begin
                        w_x_n = 5'(X_MAX);
                        w_end = 1'b1;
                    end else begin
                        w_x_n = 5'(w_x_sum);
                    end
`endif
                    if (w_end) begin
                        w_state_n = DONE;
                    end
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // State, position and status flags, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_x      <= 5'd0;
            r_y      <= 5'd0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_x      <= w_x_n;
            r_y      <= w_y_n;
            r_active <= (w_state_n == FLIGHT);
            r_done   <= (w_state_n == DONE);
        end
    end

    // Latched aim vector; only meaningful while a shot is in flight
    always_ff @(posedge clk) begin
        r_run  <= w_run_n;
        r_rise <= w_rise_n;
        r_dir  <= w_dir_n;
    end

    assign shot_active = r_active;
    assign move_lock   = r_active;
    assign shot_done   = r_done;
    assign shot_x      = r_x;
    assign shot_y      = r_y;

endmodule

// File: tb/tb_shot_ctrl.sv
// Self-checking bench for shot_ctrl against a behavioural shot model.
// Honours SHOT_BOUNCE_EN the same way as the design.
module tb_shot_ctrl;

    localparam int TICK_DIV = 4;
    localparam int Y_MAX    = 15;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fire = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] x_pos = '0;
    logic [4:0] run = '0;
    logic [4:0] rise = '0;
    logic       dir = 1'b0;
    logic       hit = 1'b0;
    logic       shot_active;
    logic [4:0] shot_x;
    logic [4:0] shot_y;
    logic       shot_done;
    logic       move_lock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the shot
    bit m_fly = 0;
    bit m_end = 0;
    int m_x = 0, m_y = 0, m_run = 0, m_rise = 0, m_dir = 0, m_ticks = 0;

    shot_ctrl #(
        .TICK_DIV (TICK_DIV),
        .Y_MAX    (Y_MAX)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fire        (fire),
        .tick        (tick),
        .x_pos       (x_pos),
        .run         (run),
        .rise        (rise),
        .dir         (dir),
        .hit         (hit),
        .shot_active (shot_active),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_done   (shot_done),
        .move_lock   (move_lock)
    );

    always #5 clk = ~clk;

    task model_reset;
        m_fly = 0; m_end = 0; m_x = 0; m_y = 0; m_ticks = 0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled
    task model_edge;
        int nx, ny;
        bit fin;
        if (m_end) begin
            m_end = 0;
        end else if (!m_fly) begin
            if (fire) begin
                m_x = x_pos; m_y = 0; m_run = run; m_dir = dir;
                m_rise = (rise == 0) ? 1 : rise;
                m_ticks = 0; m_fly = 1;
            end
        end else if (hit) begin
            m_fly = 0; m_end = 1;
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == TICK_DIV) begin
                m_ticks = 0;
                fin = 0;
                ny = m_y + m_rise;
                nx = (m_dir != 0) ? m_x + m_run : m_x - m_run;
                if (ny > Y_MAX) begin m_y = Y_MAX; fin = 1; end
                else m_y = ny;
`ifdef SHOT_BOUNCE_EN
                if (nx < 0) begin m_x = -nx; m_dir = 1 - m_dir; end
                else if (nx > 31) begin m_x = 62 - nx; m_dir = 1 - m_dir; end
                else m_x = nx;
`else
                if (nx < 0) begin m_x = 0; fin = 1; end
                else if (nx > 31) begin m_x = 31; fin = 1; end
                else m_x = nx;
`endif
                if (fin) begin m_fly = 0; m_end = 1; end
            end
        end
    endtask

    task cyc(input bit f, input bit t, input bit h);
        fire = f; tick = t; hit = h;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task drain;
        for (int i = 0; i < 400 && (m_fly || m_end); i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    task test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({shot_active, shot_done, move_lock, shot_x, shot_y} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got act=%b done=%b lock=%b x=%0d y=%0d, want all 0",
                     shot_active, shot_done, move_lock, shot_x, shot_y);
        end
        model_reset();
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task test_vertical;
        x_pos = 5'd10; run = 5'd0; rise = 5'd1; dir = 1'b0;
        cyc(1, 0, 0);
        n_tests++;
        if (!(shot_active === 1'b1 && move_lock === 1'b1 && shot_x === 5'd10 && shot_y === 5'd0)) begin
            n_fail++;
            $display("FAIL vert_launch: got act=%b lock=%b x=%0d y=%0d, want 1 1 10 0",
                     shot_active, move_lock, shot_x, shot_y);
        end
        for (int s = 1; s <= 16; s++) begin
            for (int k = 0; k < TICK_DIV; k++) begin
                cyc(0, 0, 0);
                cyc(0, 1, 0);
            end
            n_tests++;
            if (shot_x !== 5'd10 || shot_y !== 5'((s < 16) ? s : 15) || shot_done !== (s == 16)) begin
                n_fail++;
                $display("FAIL vert_step%0d: got x=%0d y=%0d done=%b, want x=10 y=%0d done=%b",
                         s, shot_x, shot_y, shot_done, (s < 16) ? s : 15, (s == 16));
            end
        end
        cyc(0, 0, 0);
        n_tests++;
        if (shot_done !== 1'b0 || shot_active !== 1'b0) begin
            n_fail++;
            $display("FAIL vert_idle: got done=%b act=%b, want 0 0", shot_done, shot_active);
        end
    endtask

    task test_hit;
        x_pos = 5'd5; run = 5'd1; rise = 5'd2; dir = 1'b1;
        cyc(1, 0, 0);
        repeat (TICK_DIV - 1) cyc(0, 1, 0);
        cyc(0, 1, 1);
        n_tests++;
        if (shot_x !== 5'd5 || shot_y !== 5'd0 || shot_done !== 1'b1 || shot_active !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_prio: got x=%0d y=%0d done=%b act=%b, want 5 0 1 0",
                     shot_x, shot_y, shot_done, shot_active);
        end
        cyc(0, 0, 0);
        n_tests++;
        if (shot_done !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_done_width: got done=%b on 2nd cycle, want 0", shot_done);
        end
    endtask

    task test_left_wall;
        x_pos = 5'd1; run = 5'd2; rise = 5'd1; dir = 1'b0;
        cyc(1, 0, 0);
        repeat (TICK_DIV) cyc(0, 1, 0);
`ifdef SHOT_BOUNCE_EN
        n_tests++;
        if (shot_x !== 5'd1 || shot_y !== 5'd1 || shot_active !== 1'b1) begin
            n_fail++;
            $display("FAIL left_bounce1: got x=%0d y=%0d act=%b, want 1 1 1", shot_x, shot_y, shot_active);
        end
        repeat (TICK_DIV) cyc(0, 1, 0);
        n_tests++;
        if (shot_x !== 5'd3 || shot_y !== 5'd2) begin
            n_fail++;
            $display("FAIL left_bounce2: got x=%0d y=%0d, want 3 2", shot_x, shot_y);
        end
`else
        n_tests++;
        if (shot_x !== 5'd0 || shot_y !== 5'd1 || shot_done !== 1'b1 || shot_active !== 1'b0) begin
            n_fail++;
            $display("FAIL left_absorb: got x=%0d y=%0d done=%b act=%b, want 0 1 1 0",
                     shot_x, shot_y, shot_done, shot_active);
        end
`endif
        drain();
    endtask

    task test_right_wall;
        x_pos = 5'd30; run = 5'd2; rise = 5'd1; dir = 1'b1;
        cyc(1, 0, 0);
        repeat (TICK_DIV) cyc(0, 1, 0);
`ifdef SHOT_BOUNCE_EN
        n_tests++;
        if (shot_x !== 5'd30 || shot_y !== 5'd1 || shot_active !== 1'b1) begin
            n_fail++;
            $display("FAIL right_bounce: got x=%0d y=%0d act=%b, want 30 1 1", shot_x, shot_y, shot_active);
        end
`else
        n_tests++;
        if (shot_x !== 5'd31 || shot_done !== 1'b1 || shot_active !== 1'b0) begin
            n_fail++;
            $display("FAIL right_absorb: got x=%0d done=%b act=%b, want 31 1 0", shot_x, shot_done, shot_active);
        end
`endif
        drain();
    endtask

    task test_fire_ignored;
        x_pos = 5'd7; run = 5'd3; rise = 5'd0; dir = 1'b1;
        cyc(1, 0, 0);
        x_pos = 5'd20; run = 5'd9; rise = 5'd7; dir = 1'b0;
        repeat (TICK_DIV) cyc(1, 1, 0);
        n_tests++;
        if (shot_x !== 5'd10 || shot_y !== 5'd1 || shot_active !== 1'b1) begin
            n_fail++;
            $display("FAIL fire_in_flight: got x=%0d y=%0d act=%b, want 10 1 1", shot_x, shot_y, shot_active);
        end
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        n_tests++;
        if (shot_active !== 1'b0 || shot_done !== 1'b0 || shot_x !== 5'd10 || shot_y !== 5'd1) begin
            n_fail++;
            $display("FAIL fire_in_done: got act=%b done=%b x=%0d y=%0d, want 0 0 10 1",
                     shot_active, shot_done, shot_x, shot_y);
        end
        cyc(1, 0, 0);
        n_tests++;
        if (shot_active !== 1'b1 || shot_x !== 5'd20 || shot_y !== 5'd0) begin
            n_fail++;
            $display("FAIL relaunch: got act=%b x=%0d y=%0d, want 1 20 0", shot_active, shot_x, shot_y);
        end
        cyc(0, 0, 1);
        drain();
    endtask

    task test_reset_midflight;
        x_pos = 5'd12; run = 5'd1; rise = 5'd3; dir = 1'b1;
        cyc(1, 0, 0);
        repeat (TICK_DIV + 2) cyc(0, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({shot_active, shot_done, move_lock, shot_x, shot_y} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_midflight: got act=%b done=%b lock=%b x=%0d y=%0d, want all 0",
                     shot_active, shot_done, move_lock, shot_x, shot_y);
        end
        model_reset();
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        x_pos = 5'd4; run = 5'd0; rise = 5'd2; dir = 1'b0;
        cyc(1, 0, 0);
        repeat (TICK_DIV) cyc(0, 1, 0);
        n_tests++;
        if (shot_x !== 5'd4 || shot_y !== 5'd2 || shot_active !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_step: got x=%0d y=%0d act=%b, want 4 2 1", shot_x, shot_y, shot_active);
        end
        drain();
    endtask

    task test_random;
        for (int i = 0; i < 1500; i++) begin
            x_pos = 5'($urandom);
            run   = 5'($urandom_range(0, 12));
            rise  = 5'($urandom_range(0, 4));
            dir   = 1'($urandom);
            cyc(($urandom % 4) == 0, ($urandom % 2) == 0, ($urandom % 40) == 0);
            n_tests++;
            if ({shot_active, shot_done, move_lock, shot_x, shot_y} !==
                {m_fly, m_end, m_fly, 5'(m_x), 5'(m_y)}) begin
                n_fail++;
                $display("FAIL random_c%0d: got act=%b done=%b lock=%b x=%0d y=%0d, want act=%b done=%b x=%0d y=%0d",
                         i, shot_active, shot_done, move_lock, shot_x, shot_y, m_fly, m_end, m_x, m_y);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_hit();
        test_left_wall();
        test_right_wall();
        test_fire_ignored();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
